pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_if.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 156 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and the PLL, the restart source and the reset fabric.
// The supervisor uses the slave modport; the PLL/controller side uses the master modport.
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       lost_lock;
    logic       fail;
    logic [3:0] retry_cnt;

    modport master (
        output pll_lock, restart,
        input  pll_reset, sys_rst_n, locked, lost_lock, fail, retry_cnt
    );

    modport slave (
        input  pll_lock, restart,
        output pll_reset, sys_rst_n, locked, lost_lock, fail, retry_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock watchdog; releases sys_rst_n only after lock has been continuously stable.
// Latency: pll_lock is seen 2 cycles late through the synchroniser; outputs are registered; no backpressure.
module pll_lock_supervisor #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    pll_lock_supervisor_if.slave bus
);
    localparam int RW = $clog2(RST_PULSE) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam logic [RW-1:0] RST_END   = RW'(RST_PULSE);
    localparam logic [TW-1:0] TO_END    = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] STAB_END  = SW'(LOCK_STABLE);
    localparam logic [3:0]    RETRY_END = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          lock_s_q;
    logic [RW-1:0] rst_cnt_q;
    logic [RW-1:0] rst_cnt_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [SW-1:0] stab_cnt_q;
    logic [SW-1:0] stab_cnt_d;
    logic [3:0]    retry_q;
    logic [3:0]    retry_d;
    logic          pll_reset_q;
    logic          sys_rst_n_q;
    logic          locked_q;
    logic          lost_lock_q;
    logic          fail_q;
    logic          run_go;
    logic          timeout;

    assign rst_cnt_d  = rst_cnt_q + RW'(1);
    assign timer_d    = timer_q + TW'(1);
    assign stab_cnt_d = stab_cnt_q + SW'(1);
    assign retry_d    = retry_q + 4'd1;

    // Reaching RUN on the same edge as the timeout takes precedence over the retry.
    assign run_go  = (state_q == S_STABLE) && lock_s_q && (stab_cnt_d == STAB_END);
    assign timeout = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) &&
                     (timer_d == TO_END) && !run_go;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= '0;
            timer_q     <= '0;
            stab_cnt_q  <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync1_q     <= bus.pll_lock;
            lock_s_q    <= sync1_q;
            lost_lock_q <= 1'b0;
            if (bus.restart) begin
                state_q     <= S_RESET_PLL;
                rst_cnt_q   <= '0;
                timer_q     <= '0;
                stab_cnt_q  <= '0;
                retry_q     <= '0;
                pll_reset_q <= 1'b1;
                sys_rst_n_q <= 1'b0;
                locked_q    <= 1'b0;
                fail_q      <= 1'b0;
            end else if (timeout) begin
                retry_q     <= retry_d;
                rst_cnt_q   <= '0;
                pll_reset_q <= 1'b1;
                if (retry_d == RETRY_END) begin
                    state_q <= S_FAIL;
                    fail_q  <= 1'b1;
                end else begin
                    state_q <= S_RESET_PLL;
                end
            end else begin
                case (state_q)
                    S_RESET_PLL: begin
                        if (rst_cnt_d == RST_END) begin
                            state_q     <= S_WAIT_LOCK;
                            timer_q     <= '0;
                            pll_reset_q <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_d;
                        end
                    end
                    S_WAIT_LOCK: begin
                        timer_q <= timer_d;
                        if (lock_s_q) begin
                            state_q    <= S_STABLE;
                            stab_cnt_q <= '0;
                        end
                    end
                    S_STABLE: begin
                        timer_q <= timer_d;
                        if (run_go) begin
                            state_q     <= S_RUN;
                            sys_rst_n_q <= 1'b1;
                            locked_q    <= 1'b1;
                            retry_q     <= '0;
                        end else if (!lock_s_q) begin
                            state_q    <= S_WAIT_LOCK;
                            stab_cnt_q <= '0;
                        end else begin
                            stab_cnt_q <= stab_cnt_d;
                        end
                    end
                    S_RUN: begin
                        // Lock loss is not a failed attempt, so retry_q is left at zero.
                        if (!lock_s_q) begin
                            state_q     <= S_RESET_PLL;
                            rst_cnt_q   <= '0;
                            pll_reset_q <= 1'b1;
                            sys_rst_n_q <= 1'b0;
                            locked_q    <= 1'b0;
                            lost_lock_q <= 1'b1;
                        end
                    end
                    S_FAIL: begin
                        state_q <= S_FAIL;
                    end
                    default: begin
                        state_q <= S_RESET_PLL;
                    end
                endcase
            end
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.locked    = locked_q;
    assign bus.lost_lock = lost_lock_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: scenario tasks plus a random lock trace, checked against an event-timing model.
module tb_pll_lock_supervisor;
    localparam int RST_PULSE    = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int LOCK_STABLE  = 16;
    localparam int MAX_RETRY    = 3;
    localparam logic [8:0] RESET_VALS = 9'b1_0_0_0_0_0000;

    logic clkin = 1'b0;
    logic rst_n;
    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .RST_PULSE   (RST_PULSE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin(clkin),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    logic [8:0] dut_o;
    assign dut_o = {bus.pll_reset, bus.sys_rst_n, bus.locked, bus.lost_lock, bus.fail, bus.retry_cnt};

    int total = 0;
    int bad   = 0;

    // Reference model: timestamps of the current phase plus a run-length of synchronised lock highs.
    localparam int M_PULSE = 0, M_SEARCH = 1, M_UP = 2, M_DEAD = 3;
    int   mode, cyc, pulse_start, search_start, run_len, retries;
    bit   lost;
    logic hist[$];

    task automatic model_reset();
        mode = M_PULSE; cyc = 0; pulse_start = 0; search_start = 0;
        run_len = 0; retries = 0; lost = 1'b0;
        hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
    endtask

    task automatic model_edge(input logic l, input logic r);
        logic s;
        cyc++;
        s = hist[hist.size()-2];
        hist.push_back(l);
        if (hist.size() > 4) void'(hist.pop_front());
        lost = 1'b0;
        if (r) begin
            mode = M_PULSE; pulse_start = cyc; retries = 0;
        end else begin
            case (mode)
                M_PULSE: if (cyc - pulse_start == RST_PULSE) begin
                    mode = M_SEARCH; search_start = cyc; run_len = 0;
                end
                M_SEARCH: begin
                    run_len = s ? run_len + 1 : 0;
                    if (run_len == LOCK_STABLE + 1) begin
                        mode = M_UP; retries = 0;
                    end else if (cyc - search_start == LOCK_TIMEOUT) begin
                        retries++;
                        if (retries == MAX_RETRY) mode = M_DEAD;
                        else begin mode = M_PULSE; pulse_start = cyc; end
                    end
                end
                M_UP: if (!s) begin
                    mode = M_PULSE; pulse_start = cyc; lost = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [8:0] mdl_o();
        logic pr, up, dead;
        pr   = (mode == M_PULSE) || (mode == M_DEAD);
        up   = (mode == M_UP);
        dead = (mode == M_DEAD);
        return {pr, up, up, lost, dead, 4'(retries)};
    endfunction

    task automatic step(input logic l, input logic r);
        bus.pll_lock = l;
        bus.restart  = r;
        @(posedge clkin);
        model_edge(l, r);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.pll_lock = 1'b0; bus.restart = 1'b0;
        #7;
        total++;
        if (dut_o !== RESET_VALS) begin bad++; $display("FAIL reset_vals got=%b want=%b", dut_o, RESET_VALS); end
        @(posedge clkin); #2;
        total++;
        if (dut_o !== RESET_VALS) begin bad++; $display("FAIL reset_held got=%b want=%b", dut_o, RESET_VALS); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean_lock();
        int fall_edge = -1, rise_edge = -1, e0;
        for (int i = 0; i < RST_PULSE + 19; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL clean_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (fall_edge < 0 && bus.pll_reset === 1'b0) fall_edge = cyc;
        end
        total++;
        if (fall_edge !== RST_PULSE) begin bad++; $display("FAIL clean_pulse_len got=%0d want=%0d", fall_edge, RST_PULSE); end
        e0 = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL clean_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (rise_edge < 0 && bus.sys_rst_n === 1'b1) rise_edge = cyc;
        end
        total++;
        if (rise_edge !== e0 + 2 + LOCK_STABLE) begin bad++; $display("FAIL clean_release got=%0d want=%0d", rise_edge, e0 + 2 + LOCK_STABLE); end
        total++;
        if ({bus.locked, bus.retry_cnt} !== 5'b1_0000) begin bad++; $display("FAIL clean_run got=%b want=10000", {bus.locked, bus.retry_cnt}); end
    endtask

    task automatic test_lock_loss();
        int f, lost_edge = -1, lost_cnt = 0;
        f = cyc;
        step(1'b0, 1'b0);
        total++;
        if (dut_o !== mdl_o()) begin bad++; $display("FAIL loss_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL loss_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (bus.lost_lock === 1'b1) begin
                lost_cnt++;
                if (lost_edge < 0) lost_edge = cyc;
                total++;
                if ({bus.pll_reset, bus.sys_rst_n} !== 2'b10) begin bad++; $display("FAIL loss_resets got=%b want=10", {bus.pll_reset, bus.sys_rst_n}); end
            end
        end
        total++;
        if (lost_edge !== f + 3 || lost_cnt !== 1) begin bad++; $display("FAIL loss_pulse got edge=%0d n=%0d want edge=%0d n=1", lost_edge, lost_cnt, f + 3); end
        total++;
        if ({bus.locked, bus.retry_cnt} !== 5'b1_0000) begin bad++; $display("FAIL loss_relock got=%b want=10000", {bus.locked, bus.retry_cnt}); end
    endtask

    task automatic test_glitchy_lock();
        int r, rise_edge = -1;
        logic l;
        step(1'b0, 1'b1);
        r = cyc;
        for (int i = 1; i <= 50; i++) begin
            l = ((i >= RST_PULSE + 5) && (i <= RST_PULSE + 14)) || (i >= RST_PULSE + 16);
            step(l, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL glitch_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (rise_edge < 0 && bus.sys_rst_n === 1'b1) rise_edge = cyc;
        end
        total++;
        if (rise_edge !== r + RST_PULSE + 16 + 2 + LOCK_STABLE) begin bad++; $display("FAIL glitch_release got=%0d want=%0d", rise_edge, r + RST_PULSE + 34); end
        total++;
        if (bus.retry_cnt !== 4'd0) begin bad++; $display("FAIL glitch_retry got=%0d want=0", bus.retry_cnt); end
    endtask

    task automatic test_timeout_fail();
        int r, fail_edge = -1, chg[$];
        logic [3:0] prev;
        step(1'b0, 1'b1);
        r = cyc; prev = bus.retry_cnt;
        for (int i = 0; i < 240; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL timeout_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (bus.retry_cnt !== prev) chg.push_back(cyc);
            prev = bus.retry_cnt;
            if (fail_edge < 0 && bus.fail === 1'b1) fail_edge = cyc;
        end
        total++;
        if (chg.size() != MAX_RETRY) begin
            bad++; $display("FAIL timeout_retry_steps got=%0d want=%0d", chg.size(), MAX_RETRY);
        end else begin
            for (int k = 0; k < MAX_RETRY; k++) begin
                total++;
                if (chg[k] != r + (k + 1) * (RST_PULSE + LOCK_TIMEOUT)) begin
                    bad++; $display("FAIL timeout_retry_edge k=%0d got=%0d want=%0d", k, chg[k], r + (k + 1) * (RST_PULSE + LOCK_TIMEOUT));
                end
            end
        end
        total++;
        if (fail_edge !== r + MAX_RETRY * (RST_PULSE + LOCK_TIMEOUT)) begin bad++; $display("FAIL timeout_fail_edge got=%0d want=%0d", fail_edge, r + 216); end
        total++;
        if ({bus.pll_reset, bus.sys_rst_n, bus.fail, bus.retry_cnt} !== 7'b1_0_1_0011) begin
            bad++; $display("FAIL timeout_fail_hold got=%b want=1010011", {bus.pll_reset, bus.sys_rst_n, bus.fail, bus.retry_cnt});
        end
    endtask

    task automatic test_restart_coincident();
        step(1'b0, 1'b1);
        total++;
        if ({bus.fail, bus.retry_cnt, bus.pll_reset} !== 6'b0_0000_1) begin bad++; $display("FAIL restart_from_fail got=%b want=000001", {bus.fail, bus.retry_cnt, bus.pll_reset}); end
        for (int i = 1; i < RST_PULSE + LOCK_TIMEOUT; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL coincide_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
        end
        step(1'b0, 1'b1);
        total++;
        if (dut_o !== 9'b1_0_0_0_0_0000) begin bad++; $display("FAIL coincide_restart got=%b want=100000000", dut_o); end
        for (int i = 0; i < RST_PULSE; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL coincide_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
        end
        total++;
        if (bus.pll_reset !== 1'b0) begin bad++; $display("FAIL coincide_pulse got=%b want=0", bus.pll_reset); end
    endtask

    task automatic test_async_reset();
        int rise_edge = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL async_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dut_o !== RESET_VALS) begin bad++; $display("FAIL async_stable got=%b want=%b", dut_o, RESET_VALS); end
        @(posedge clkin); #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL async_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
            if (rise_edge < 0 && bus.locked === 1'b1) rise_edge = cyc;
        end
        total++;
        if (rise_edge !== RST_PULSE + 1 + LOCK_STABLE) begin bad++; $display("FAIL async_relock got=%0d want=%0d", rise_edge, RST_PULSE + 1 + LOCK_STABLE); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dut_o !== RESET_VALS) begin bad++; $display("FAIL async_run got=%b want=%b", dut_o, RESET_VALS); end
        @(posedge clkin); #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int   seg = 0;
        logic l = 1'b0, r;
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                l = ($urandom_range(0, 3) != 0);
                if (l) seg = $urandom_range(5, 60);
                else if ($urandom_range(0, 4) == 0) seg = $urandom_range(50, 200);
                else seg = $urandom_range(1, 4);
            end
            seg--;
            r = ($urandom_range(0, 299) == 0);
            step(l, r);
            total++;
            if (dut_o !== mdl_o()) begin bad++; $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, dut_o, mdl_o()); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_lock_loss();
        test_glitchy_lock();
        test_timeout_fail();
        test_restart_coincident();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
